alu_serial: RTL and testbench
=============================

# alu_serial

Parametrised bit-serial ALU built around a single 1-bit ALU slice (full adder plus NOT/AND/XOR/OR) that is reused once per clock. It processes a WIDTH-bit operation LSB-first over WIDTH cycles and reports the result with flags through a start/busy/done handshake. It is the multi-bit, sequential successor of the combinational 1-bit slice. It is for area-constrained datapaths where latency is acceptable.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- cin  in  1  carry-in for ADD; captured with operands.
- s  in  3  opcode; captured with operands.
- r  out  WIDTH  result register; updates only on completion.
- cout  out  1  carry-out of the operation.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  high when the completed result is all zeros.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse on completion.

## Operation
- Opcodes:
  - 000 NOT a, r=~a.
  - 001 AND, r=a&b.
  - 010 XOR, r=a^b.
  - 011 OR, r=a|b.
  - 100 ADD, r=a+b+cin.
  - 101 SUB, r=a+~b+1; cin is ignored.
  - 110 INC, r=a+1.
  - 111 PASS, r=b.
- Flags:
  - cout: final carry of the serial chain for 100/101/110; 0 for all other opcodes. For SUB, cout=1 means no borrow.
  - ovf: carry into MSB XOR carry out of MSB for 100/101/110; 0 otherwise.
  - zero: computed on the final result for every opcode.
- The arithmetic carry is a 1-bit register. Its seed at operand capture:
  - ADD: cin.
  - SUB: 1.
  - INC: 1.
  - All other opcodes: 0.
- INC uses 0 as the B bit. SUB uses the inverted B bit.
- Internal state:
  - Two WIDTH-bit shift registers for A and B, shifted right each RUN cycle.
  - One WIDTH-bit result shift register, filled from the MSB side.
  - A bit counter of ceil(log2(WIDTH+1)) bits.
  - The latched opcode.
- FSM has two states:
  - IDLE:
    - busy=0.
    - On start=1, capture a, b, cin and s, clear the counter and go to RUN.
    - start=0 stays in IDLE.
  - RUN:
    - busy=1.
    - Each cycle, process slice bit index = counter, shift all registers and increment the counter.
    - On the cycle that processes bit WIDTH-1:
      - load r from the completed result (including the final bit).
      - load cout, ovf and zero.
      - pulse done=1 for the next cycle.
      - go to IDLE.
- start while busy=1 is ignored, and is not queued.
- Changes on a, b, cin or s while busy have no effect.
- r, cout, ovf and zero hold their values until the next completion. They never show partial results.
- WIDTH=1: RUN lasts exactly one cycle. ovf = carry-in XOR carry-out of bit 0.

## Timing
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - r=0, cout=0, ovf=0, zero=0, busy=0, done=0.
  - Internal registers are cleared.
  - Reset has priority over start.
- Reset mid-operation aborts the operation. No done pulse is produced and r stays at 0.
- Latency:
  - The start accepted at edge E0 makes busy=1 after E0.
  - Bits 0..WIDTH-1 are processed at edges E1..EWIDTH.
  - After edge EWIDTH: r/flags are valid, done=1 and busy=0.
  - done deasserts after edge EWIDTH+1.
- Back-to-back: start may be high during the done cycle. It is accepted at edge EWIDTH+1. Sustained throughput is one operation per WIDTH+1 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, ADD, a=0xFF, b=0x01, cin=0 -> after 8 RUN edges, done pulses once: r=0x00, cout=1, ovf=0, zero=1; busy is high for exactly 8 cycles.
- SUB 0x05-0x07 -> r=0xFE, cout=0, ovf=0, zero=0. SUB 0x80-0x01 -> r=0x7F, cout=1, ovf=1. ADD 0x7F+0x00+cin=1 -> r=0x80, ovf=1, cout=0.
- Logic with a=0xCA, b=0x0F:
  - NOT -> 0x35.
  - AND -> 0x0A.
  - XOR -> 0xC5.
  - OR -> 0xCF.
  - PASS -> 0x0F.
  - Check cout=ovf=0 for all of the above.
  - INC 0xFF -> r=0x00, cout=1, zero=1.
- Start ADD 0x10+0x20. Then pulse start with other operands on RUN cycle 3 and toggle a/b/s every cycle -> exactly one done, r=0x30; the second start is ignored.
- Start ADD 0x01+0x01, assert rst on RUN cycle 3 -> busy=0 and done never pulses; r, cout, ovf and zero stay 0. A subsequent ADD 0x02+0x03 gives r=0x05.
- Hold start high continuously with PASS b=0x55, then PASS b=0xAA presented during the first done cycle -> done pulses 9 cycles apart, r=0x55 then r=0xAA. Repeat key cases with WIDTH=1 and WIDTH=32 (ADD 0xFFFFFFFF+1 -> r=0, cout=1).

Source files
------------

// File: rtl/alu_serial.sv
// Bit-serial ALU: a single 1-bit slice (full adder plus NOT/AND/XOR/OR) is
// reused once per clock, processing WIDTH-bit operands LSB-first.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last completed result
// RUN   | one operand bit processed per cycle, counter = bit index
module alu_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
  logic [CW-1:0]    cnt;
  logic [2:0]       op;
  logic             carry, carry_seed;
  logic             b_bit, sum, c_next, r_bit, arith;

  always_comb begin
    arith = op[2] & ~(op[1] & op[0]);
    case (op)
      3'b101:  b_bit = ~b_sh[0];
      3'b110:  b_bit = 1'b0;
      default: b_bit = b_sh[0];
    endcase
    sum    = a_sh[0] ^ b_bit ^ carry;
    c_next = (a_sh[0] & b_bit) | (a_sh[0] & carry) | (b_bit & carry);
    case (op)
      3'b000:  r_bit = ~a_sh[0];
      3'b001:  r_bit = a_sh[0] & b_sh[0];
      3'b010:  r_bit = a_sh[0] ^ b_sh[0];
      3'b011:  r_bit = a_sh[0] | b_sh[0];
      3'b111:  r_bit = b_sh[0];
      default: r_bit = sum;
    endcase
    // Result fills from the MSB side so it is aligned after WIDTH shifts.
    res_next = res_sh >> 1;
    res_next[WIDTH-1] = r_bit;
  end

  always_comb begin
    case (s)
      3'b100:         carry_seed = cin;
      3'b101, 3'b110: carry_seed = 1'b1;
      default:        carry_seed = 1'b0;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      op     <= '0;
      carry  <= 1'b0;
      r      <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            op     <= s;
            carry  <= carry_seed;
            res_sh <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        default: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= c_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            // carry holds the carry into the MSB at this point.
            r     <= res_next;
            cout  <= arith & c_next;
            ovf   <= arith & (carry ^ c_next);
            zero  <= (res_next == '0);
            done  <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial at WIDTH 8, 1 and 32: stimulus pushes the
// expected result, per-DUT monitors pop and compare on every done pulse.
module tb_alu_serial;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start1, start32;
  logic [31:0] a, b;
  logic        cin;
  logic [2:0]  s;

  logic [7:0]  r8;
  logic [0:0]  r1;
  logic [31:0] r32;
  logic cout8, ovf8, zero8, busy8, done8;
  logic cout1, ovf1, zero1, busy1, done1;
  logic cout32, ovf32, zero32, busy32, done32;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int busy8_cnt = 0;
  int last_done8 = 0;
  int prev_done8 = 0;
  exp_t q8[$];
  exp_t q1[$];
  exp_t q32[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a[7:0]), .b(b[7:0]), .cin(cin), .s(s),
    .r(r8), .cout(cout8), .ovf(ovf8), .zero(zero8), .busy(busy8), .done(done8));
  alu_serial #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a[0:0]), .b(b[0:0]), .cin(cin), .s(s),
    .r(r1), .cout(cout1), .ovf(ovf1), .zero(zero1), .busy(busy1), .done(done1));
  alu_serial #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a), .b(b), .cin(cin), .s(s),
    .r(r32), .cout(cout32), .ovf(ovf32), .zero(zero32), .busy(busy32), .done(done32));

  task automatic check(input string nm, input exp_t e, input logic [31:0] ar,
                       input logic ac, input logic ao, input logic az);
    nvec++;
    if (ar !== e.r || ac !== e.c || ao !== e.o || az !== e.z) begin
      nerr++;
      $display("FAIL %s: got r=%h c=%b o=%b z=%b, want r=%h c=%b o=%b z=%b",
               nm, ar, ac, ao, az, e.r, e.c, e.o, e.z);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (busy8) busy8_cnt <= busy8_cnt + 1;
    if (done8) begin
      prev_done8 = last_done8;
      last_done8 = cyc;
      if (q8.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_done_w8: got r=%h, want no done", r8);
      end else check("w8", q8.pop_front(), {24'b0, r8}, cout8, ovf8, zero8);
    end
    if (done1) begin
      if (q1.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_done_w1: got r=%h, want no done", r1);
      end else check("w1", q1.pop_front(), {31'b0, r1}, cout1, ovf1, zero1);
    end
    if (done32) begin
      if (q32.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_done_w32: got r=%h, want no done", r32);
      end else check("w32", q32.pop_front(), r32, cout32, ovf32, zero32);
    end
  end

  function automatic logic done_of(input int w);
    case (w)
      1:       return done1;
      32:      return done32;
      default: return done8;
    endcase
  endfunction

  task automatic push(input int w, input logic [31:0] er, input logic ec,
                      input logic eo, input logic ez);
    exp_t e;
    e.r = er; e.c = ec; e.o = eo; e.z = ez;
    case (w)
      1:       q1.push_back(e);
      32:      q32.push_back(e);
      default: q8.push_back(e);
    endcase
  endtask

  task automatic wait_done(input int w, input string nm);
    int t = 0;
    while (1) begin
      @(negedge clk);
      t++;
      if (done_of(w)) break;
      if (t > 40) begin
        nvec++; nerr++;
        $display("FAIL timeout_%s: got no done after %0d cycles, want done", nm, t);
        break;
      end
    end
  endtask

  task automatic set_start(input int w, input logic v);
    case (w)
      1:       start1 = v;
      32:      start32 = v;
      default: start8 = v;
    endcase
  endtask

  task automatic run_op(input int w, input logic [2:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic ci, input logic [31:0] er,
                        input logic ec, input logic eo, input logic ez);
    @(negedge clk);
    a = av; b = bv; s = op; cin = ci;
    push(w, er, ec, eo, ez);
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    wait_done(w, "run_op");
  endtask

  initial begin
    int b0;
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0; start32 = 1'b0;
    a = '0; b = '0; cin = 1'b0; s = '0;
    repeat (3) @(negedge clk);
    begin
      exp_t z0;
      z0.r = '0; z0.c = 1'b0; z0.o = 1'b0; z0.z = 1'b0;
      check("reset_w8", z0, {24'b0, r8}, cout8, ovf8, zero8);
      check("reset_w32", z0, r32, cout32, ovf32, zero32);
      check_int("reset_busy_done", {busy8, done8, busy1, done1, busy32, done32}, 0);
    end
    rst = 1'b0;

    // WIDTH=8 arithmetic and busy length
    b0 = busy8_cnt;
    run_op(8, 3'b100, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1);
    check_int("busy_cycles_w8", busy8_cnt - b0, 8);
    run_op(8, 3'b101, 32'h05, 32'h07, 1'b1, 32'hFE, 1'b0, 1'b0, 1'b0);
    run_op(8, 3'b101, 32'h80, 32'h01, 1'b0, 32'h7F, 1'b1, 1'b1, 1'b0);
    run_op(8, 3'b100, 32'h7F, 32'h00, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0);
    // logic ops, cin=1 must not leak into cout/ovf
    run_op(8, 3'b000, 32'hCA, 32'h0F, 1'b1, 32'h35, 1'b0, 1'b0, 1'b0);
    run_op(8, 3'b001, 32'hCA, 32'h0F, 1'b1, 32'h0A, 1'b0, 1'b0, 1'b0);
    run_op(8, 3'b010, 32'hCA, 32'h0F, 1'b1, 32'hC5, 1'b0, 1'b0, 1'b0);
    run_op(8, 3'b011, 32'hCA, 32'h0F, 1'b1, 32'hCF, 1'b0, 1'b0, 1'b0);
    run_op(8, 3'b111, 32'hCA, 32'h0F, 1'b1, 32'h0F, 1'b0, 1'b0, 1'b0);
    run_op(8, 3'b110, 32'hFF, 32'h33, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1);

    // start while busy is ignored; input changes mid-run have no effect
    @(negedge clk);
    a = 32'h10; b = 32'h20; s = 3'b100; cin = 1'b0;
    push(8, 32'h30, 1'b0, 1'b0, 1'b0);
    start8 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; s = 3'($urandom_range(0, 7)); cin = 1'($urandom_range(0, 1));
      start8 = (i == 3);
    end
    check_int("queue_empty_after_ignore", q8.size(), 0);

    // reset mid-operation aborts with no done
    @(negedge clk);
    a = 32'h01; b = 32'h01; s = 3'b100; cin = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_int("abort_busy", busy8, 0);
    repeat (12) @(negedge clk);
    begin
      exp_t z0;
      z0.r = '0; z0.c = 1'b0; z0.o = 1'b0; z0.z = 1'b0;
      check("abort_outputs", z0, {24'b0, r8}, cout8, ovf8, zero8);
    end
    run_op(8, 3'b100, 32'h02, 32'h03, 1'b0, 32'h05, 1'b0, 1'b0, 1'b0);

    // back-to-back with start held high
    @(negedge clk);
    a = 32'h00; b = 32'h55; s = 3'b111; cin = 1'b0;
    push(8, 32'h55, 1'b0, 1'b0, 1'b0);
    push(8, 32'hAA, 1'b0, 1'b0, 1'b0);
    start8 = 1'b1;
    wait_done(8, "b2b_first");
    b = 32'hAA;
    @(negedge clk);
    start8 = 1'b0;
    wait_done(8, "b2b_second");
    #1;
    check_int("b2b_spacing", last_done8 - prev_done8, 9);
    check_int("b2b_queue_empty", q8.size(), 0);

    // WIDTH=1
    run_op(1, 3'b100, 32'h1, 32'h1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    run_op(1, 3'b100, 32'h1, 32'h0, 1'b0, 32'h1, 1'b0, 1'b0, 1'b0);
    run_op(1, 3'b101, 32'h0, 32'h1, 1'b0, 32'h1, 1'b0, 1'b1, 1'b0);
    run_op(1, 3'b000, 32'h1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    run_op(1, 3'b110, 32'h0, 32'h1, 1'b0, 32'h1, 1'b0, 1'b1, 1'b0);

    // WIDTH=32
    run_op(32, 3'b100, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    run_op(32, 3'b101, 32'h0, 32'h1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run_op(32, 3'b100, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_op(32, 3'b010, 32'h12345678, 32'hFFFF0000, 1'b0, 32'hEDCB5678, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check_int("final_queues_empty", q8.size() + q1.size() + q32.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
